mem_port_arbiter: RTL and testbench

- Shares one single-port, synchronous-read, byte-writable unified memory between the core's instruction-fetch port and its data (load/store) port.
- Grants one requester per cycle and issues the memory command.
- Returns read data to the owning port one cycle later.
- Drives stall signals back to the pipeline for the port that lost arbitration.
- Sits between the riscv core and a single combined imem/dmem RAM in the top level.

---
 rtl/mem_port_arbiter.sv | 104 ++++++++++
 tb/tb_mem_port_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous-read RAM between the fetch and data ports.
// Data wins conflicts unless fetch has been denied MAX_DEFER times in a row.
module mem_port_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int MAX_DEFER = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_valid,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_valid,
    output logic                  stall_f,
    output logic                  stall_m,
    output logic                  mem_en,
    output logic [DATA_W/8-1:0]   mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int CNT_W = (MAX_DEFER > 0) ? $clog2(MAX_DEFER + 1) : 1;
    localparam logic [CNT_W-1:0] DEFER_MAX = CNT_W'(MAX_DEFER);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    owner_t            rsp_owner, rsp_owner_next;
    logic [CNT_W-1:0]  defer_cnt, defer_next;
    logic              store_ack, store_ack_next;
    logic [DATA_W-1:0] if_hold, d_hold;
    logic              fetch_wins, grant_f, grant_d;

    // Handshake: a port holds req and its fields until the cycle its stall is low;
    // that cycle is the grant, and read data returns exactly one cycle later.
    always_comb begin
        fetch_wins = (defer_cnt == DEFER_MAX);
        grant_f    = reset & if_req & (~d_req | fetch_wins);
        grant_d    = reset & d_req & ~grant_f;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_owner <= OWN_NONE;
            defer_cnt <= '0;
            store_ack <= 1'b0;
            if_hold   <= '0;
            d_hold    <= '0;
        end else begin
            rsp_owner <= rsp_owner_next;
            defer_cnt <= defer_next;
            store_ack <= store_ack_next;
            if (rsp_owner == OWN_IF) begin
                if_hold <= mem_rdata;
            end
            if (rsp_owner == OWN_D) begin
                d_hold <= mem_rdata;
            end
        end
    end

    always_comb begin
        defer_next     = defer_cnt;
        rsp_owner_next = OWN_NONE;
        store_ack_next = 1'b0;
        if (!if_req || grant_f) begin
            defer_next = '0;
        end else if (defer_cnt != DEFER_MAX) begin
            defer_next = defer_cnt + CNT_W'(1);
        end
        if (grant_f) begin
            rsp_owner_next = OWN_IF;
        end else if (grant_d && !d_we) begin
            rsp_owner_next = OWN_D;
        end
        // Stores return no data, only an acknowledge on d_valid.
        store_ack_next = grant_d & d_we;
    end

    always_comb begin
        mem_en    = grant_f | grant_d;
        mem_addr  = grant_f ? if_addr : d_addr;
        mem_we    = (grant_d && d_we) ? d_be : '0;
        mem_wdata = d_wdata;
        stall_f   = reset & if_req & ~grant_f;
        stall_m   = reset & d_req & ~grant_d;
        if_valid  = (rsp_owner == OWN_IF);
        if_rdata  = if_valid ? mem_rdata : if_hold;
        d_valid   = (rsp_owner == OWN_D) | store_ack;
        d_rdata   = (rsp_owner == OWN_D) ? mem_rdata : d_hold;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural byte-writable RAM, shadow memory model
// and per-port expected-response queues checked whenever a valid appears.
module tb_mem_port_arbiter;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int G_NONE = 0;
    localparam int G_F    = 1;
    localparam int G_D    = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [BE_W-1:0]   d_be = '0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    logic              stall_f, stall_m, mem_en;
    logic [BE_W-1:0]   mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    int checks = 0;
    int failures = 0;
    logic [DATA_W-1:0] exp_if_q[$];
    logic [DATA_W-1:0] exp_d_q[$];
    logic [DATA_W-1:0] ram[256];
    logic [DATA_W-1:0] shadow[256];
    logic [DATA_W-1:0] exp_last_d = '0;
    logic              pre_en = 1'b0;
    logic [7:0]        pre_idx = '0;
    logic [DATA_W-1:0] pre_data = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DEFER(3)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .stall_f(stall_f), .stall_m(stall_m),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Synchronous-read, byte-writable RAM; preload port used only while the DUT is in reset.
    always @(posedge clk) begin
        if (pre_en) begin
            ram[pre_idx] <= pre_data;
        end else if (mem_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (mem_we[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            mem_rdata <= ram[mem_addr[9:2]];
        end
    end

    // Scoreboard: every valid pops one expected value from its port's queue.
    always @(negedge clk) begin
        logic [DATA_W-1:0] e;
        if (if_valid === 1'b1) begin
            checks++;
            if (exp_if_q.size() == 0) begin
                failures++;
                $display("FAIL if_rsp unexpected if_valid got=%h", if_rdata);
            end else begin
                e = exp_if_q.pop_front();
                if (if_rdata !== e) begin
                    failures++;
                    $display("FAIL if_rsp got=%h exp=%h", if_rdata, e);
                end
            end
        end
        if (d_valid === 1'b1) begin
            checks++;
            if (exp_d_q.size() == 0) begin
                failures++;
                $display("FAIL d_rsp unexpected d_valid got=%h", d_rdata);
            end else begin
                e = exp_d_q.pop_front();
                if (d_rdata !== e) begin
                    failures++;
                    $display("FAIL d_rsp got=%h exp=%h", d_rdata, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [DATA_W-1:0] init_word(input int i);
        case (i)
            0:       return 32'h00100093;
            1:       return 32'h00200113;
            2:       return 32'h00300193;
            3:       return 32'h00400213;
            4:       return 32'h00500093;
            128:     return 32'h12345678;
            default: return (32'(i) * 32'h01010101) ^ 32'hA5A50000;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fr, input logic [ADDR_W-1:0] fa, input logic dr,
                         input logic we, input logic [BE_W-1:0] be,
                         input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] wd);
        if_req = fr; if_addr = fa; d_req = dr; d_we = we; d_be = be; d_addr = da; d_wdata = wd;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // Records the response the driven request must produce, using the shadow memory.
    task automatic expect_grant(input int g);
        if (g == G_F) begin
            exp_if_q.push_back(shadow[if_addr[9:2]]);
        end else if (g == G_D) begin
            if (d_we) begin
                exp_d_q.push_back(exp_last_d);
                for (int b = 0; b < BE_W; b++) begin
                    if (d_be[b]) shadow[d_addr[9:2]][8*b +: 8] = d_wdata[8*b +: 8];
                end
            end else begin
                exp_last_d = shadow[d_addr[9:2]];
                exp_d_q.push_back(exp_last_d);
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            pre_en = 1'b1; pre_idx = 8'(i); pre_data = init_word(i);
            shadow[i] = init_word(i);
        end
        @(negedge clk);
        pre_en = 1'b0;
        drive(1'b1, 10'h020, 1'b1, 1'b0, '0, 10'h040, '0);
        @(negedge clk);
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rst_if_valid got=%b exp=0", if_valid); end
        checks++; if (d_valid !== 1'b0) begin failures++; $display("FAIL rst_d_valid got=%b exp=0", d_valid); end
        checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL rst_mem_en got=%b exp=0", mem_en); end
        checks++; if (mem_we !== 4'b0) begin failures++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
        checks++; if (stall_f !== 1'b0 || stall_m !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b%b exp=00", stall_f, stall_m); end
        checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h/%h exp=0/0", if_rdata, d_rdata); end
        #1 reset = 1'b1;
        #1;
        checks++; if (stall_f !== 1'b1 || stall_m !== 1'b0) begin failures++; $display("FAIL rel_stall got=%b%b exp=10", stall_f, stall_m); end
        checks++; if (mem_en !== 1'b1 || mem_addr !== 10'h040) begin failures++; $display("FAIL rel_grant got en=%b addr=%h exp en=1 addr=040", mem_en, mem_addr); end
        expect_grant(G_D);
        step();
        idle();
    endtask

    task automatic test_fetch_only();
        step();
        drive(1'b1, 10'h010, 1'b0, 1'b0, '0, '0, '0);
        expect_grant(G_F);
        @(negedge clk);
        checks++; if (mem_en !== 1'b1 || mem_we !== 4'b0) begin failures++; $display("FAIL fetch_cmd got en=%b we=%b exp en=1 we=0", mem_en, mem_we); end
        checks++; if (mem_addr !== 10'h010) begin failures++; $display("FAIL fetch_addr got=%h exp=010", mem_addr); end
        checks++; if (stall_f !== 1'b0) begin failures++; $display("FAIL fetch_stall got=%b exp=0", stall_f); end
        step();
        idle();
        @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_rdata !== 32'h00500093) begin failures++; $display("FAIL fetch_rsp got v=%b d=%h exp v=1 d=00500093", if_valid, if_rdata); end
    endtask

    task automatic test_store_load();
        step();
        drive(1'b0, '0, 1'b1, 1'b1, 4'b0011, 10'h200, 32'hDEADBEEF);
        expect_grant(G_D);
        @(negedge clk);
        checks++; if (mem_en !== 1'b1 || mem_we !== 4'b0011) begin failures++; $display("FAIL store_we got en=%b we=%b exp en=1 we=0011", mem_en, mem_we); end
        checks++; if (mem_addr !== 10'h200 || mem_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL store_cmd got addr=%h wd=%h exp 200/deadbeef", mem_addr, mem_wdata); end
        checks++; if (stall_m !== 1'b0) begin failures++; $display("FAIL store_stall got=%b exp=0", stall_m); end
        step();
        drive(1'b0, '0, 1'b1, 1'b0, '0, 10'h200, '0);
        expect_grant(G_D);
        @(negedge clk);
        checks++; if (d_valid !== 1'b1) begin failures++; $display("FAIL store_ack got=%b exp=1", d_valid); end
        checks++; if (mem_we !== 4'b0 || mem_en !== 1'b1) begin failures++; $display("FAIL load_cmd got en=%b we=%b exp en=1 we=0", mem_en, mem_we); end
        step();
        idle();
        @(negedge clk);
        checks++; if (d_valid !== 1'b1 || d_rdata !== 32'h1234BEEF) begin failures++; $display("FAIL load_merge got v=%b d=%h exp v=1 d=1234beef", d_valid, d_rdata); end
    endtask

    task automatic test_conflict();
        logic [7:0] exp_f;
        exp_f = 8'b1000_1000;
        for (int i = 0; i < 8; i++) begin
            step();
            drive(1'b1, 10'h0C0, 1'b1, 1'b0, '0, 10'h0E0, '0);
            expect_grant(exp_f[i] ? G_F : G_D);
            @(negedge clk);
            checks++;
            if (stall_f !== ~exp_f[i] || stall_m !== exp_f[i] || mem_addr !== (exp_f[i] ? 10'h0C0 : 10'h0E0)) begin
                failures++;
                $display("FAIL conflict_c%0d got sf=%b sm=%b addr=%h exp sf=%b sm=%b", i, stall_f, stall_m, mem_addr, ~exp_f[i], exp_f[i]);
            end
        end
        step();
        idle();
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        step();
        drive(1'b1, 10'h010, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        checks++; if (mem_en !== 1'b1) begin failures++; $display("FAIL midrst_grant got=%b exp=1", mem_en); end
        #1 reset = 1'b0;
        idle();
        step();
        @(negedge clk);
        checks++; if (if_valid !== 1'b0 || if_rdata !== 32'h0) begin failures++; $display("FAIL midrst_in_reset got v=%b d=%h exp v=0 d=0", if_valid, if_rdata); end
        #1 reset = 1'b1;
        exp_last_d = '0;
        for (int i = 0; i < 2; i++) begin
            step();
            @(negedge clk);
            checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL midrst_after c%0d got=%b exp=0", i, if_valid); end
        end
    endtask

    task automatic test_idle_burst();
        for (int i = 0; i < 3; i++) begin
            step();
            idle();
            @(negedge clk);
            checks++; if (mem_en !== 1'b0 || if_valid !== 1'b0 || d_valid !== 1'b0) begin failures++; $display("FAIL idle_c%0d got en=%b iv=%b dv=%b exp 0/0/0", i, mem_en, if_valid, d_valid); end
        end
        for (int i = 0; i < 4; i++) begin
            step();
            drive(1'b1, 10'(i * 4), 1'b0, 1'b0, '0, '0, '0);
            expect_grant(G_F);
            @(negedge clk);
            checks++; if (mem_en !== 1'b1 || stall_f !== 1'b0) begin failures++; $display("FAIL burst_grant c%0d got en=%b sf=%b exp 1/0", i, mem_en, stall_f); end
            if (i > 0) begin
                checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL burst_valid c%0d got=%b exp=1", i, if_valid); end
            end
        end
        step();
        idle();
        @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_rdata !== 32'h00400213) begin failures++; $display("FAIL burst_last got v=%b d=%h exp v=1 d=00400213", if_valid, if_rdata); end
        step();
        @(negedge clk);
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL burst_end got=%b exp=0", if_valid); end
    endtask

    task automatic test_back_to_back();
        int op;
        for (int i = 0; i < 60; i++) begin
            step();
            op = $urandom_range(0, 3);
            case (op)
                1: drive(1'b1, 10'h300 + 10'($urandom_range(0, 7) * 4), 1'b0, 1'b0, '0, '0, '0);
                2: drive(1'b0, '0, 1'b1, 1'b0, '0, 10'h300 + 10'($urandom_range(0, 7) * 4), '0);
                3: drive(1'b0, '0, 1'b1, 1'b1, 4'($urandom_range(1, 15)),
                         10'h300 + 10'($urandom_range(0, 7) * 4), $urandom);
                default: idle();
            endcase
            expect_grant(op == 1 ? G_F : (op >= 2 ? G_D : G_NONE));
            @(negedge clk);
            checks++; if (mem_en !== (op != 0)) begin failures++; $display("FAIL b2b_en c%0d got=%b exp=%b", i, mem_en, op != 0); end
        end
        step();
        idle();
        step();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_store_load();
        test_conflict();
        test_reset_mid_read();
        test_idle_burst();
        test_back_to_back();
        checks++; if (exp_if_q.size() != 0) begin failures++; $display("FAIL drain_if left=%0d exp=0", exp_if_q.size()); end
        checks++; if (exp_d_q.size() != 0) begin failures++; $display("FAIL drain_d left=%0d exp=0", exp_d_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
